// File: rtl/pipelined_carry_chain_adder.sv
// Pipelined W-bit add/subtract: one SEG-bit carry-chain segment per stage, operands
// skewed forward and finished segments carried along so each result leaves aligned.
module pipelined_carry_chain_adder #(
  parameter int W   = 64,
  parameter int SEG = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic         ovf
);

  localparam int NSTG = W / SEG;

  generate
    if ((W % SEG) != 0 || (SEG % 2) != 0) begin : g_param_check
      $error("pipelined_carry_chain_adder: W must be a multiple of SEG and SEG must be even");
    end
  endgenerate

  // One segment built from 2-bit slices; the carry ripples through all slices in-cycle.
  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic           ci);
    logic [SEG:0] r;
    logic [2:0]   t;
    logic         c;
    r = '0;
    c = ci;
    for (int i = 0; i < SEG / 2; i++) begin
      t = {1'b0, x[2*i +: 2]} + {1'b0, y[2*i +: 2]} + {2'b00, c};
      r[2*i +: 2] = t[1:0];
      c = t[2];
    end
    r[SEG] = c;
    return r;
  endfunction

  logic         adv;
  logic [W-1:0] b_eff;
  logic         cin_eff;

  // Per-stage registers: index k holds the beat after segment k has been summed.
  logic         vld_p [NSTG];
  logic [W-1:0] a_p   [NSTG];
  logic [W-1:0] b_p   [NSTG];
  logic [W-1:0] sum_p [NSTG];
  logic         cy_p  [NSTG];

  logic         vld_d   [NSTG];
  logic [W-1:0] a_d     [NSTG];
  logic [W-1:0] b_d     [NSTG];
  logic [W-1:0] sum_d   [NSTG];
  logic         cy_d    [NSTG];
  logic [SEG:0] seg_res [NSTG];

  assign out_valid = vld_p[NSTG-1];
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;
  assign b_eff     = sub ? ~b : b;
  assign cin_eff   = sub | c_in;

  always_comb begin
    for (int k = 0; k < NSTG; k++) begin
      vld_d[k]   = 1'b0;
      a_d[k]     = '0;
      b_d[k]     = '0;
      sum_d[k]   = '0;
      cy_d[k]    = 1'b0;
      seg_res[k] = '0;
    end

    // Stage 0: segment 0 straight from the accepted operands
    seg_res[0]          = seg_add(a[SEG-1:0], b_eff[SEG-1:0], cin_eff);
    vld_d[0]            = in_valid;
    a_d[0]              = a;
    b_d[0]              = b_eff;
    sum_d[0][SEG-1:0]   = seg_res[0][SEG-1:0];
    cy_d[0]             = seg_res[0][SEG];

    // Stage k: segment k from the skewed operands and the registered carry
    for (int k = 1; k < NSTG; k++) begin
      seg_res[k]               = seg_add(a_p[k-1][k*SEG +: SEG], b_p[k-1][k*SEG +: SEG], cy_p[k-1]);
      vld_d[k]                 = vld_p[k-1];
      a_d[k]                   = a_p[k-1];
      b_d[k]                   = b_p[k-1];
      sum_d[k]                 = sum_p[k-1];
      sum_d[k][k*SEG +: SEG]   = seg_res[k][SEG-1:0];
      cy_d[k]                  = seg_res[k][SEG];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NSTG; k++) begin
        vld_p[k] <= 1'b0;
        a_p[k]   <= '0;
        b_p[k]   <= '0;
        sum_p[k] <= '0;
        cy_p[k]  <= 1'b0;
      end
    end else if (adv) begin
      for (int k = 0; k < NSTG; k++) begin
        vld_p[k] <= vld_d[k];
        a_p[k]   <= a_d[k];
        b_p[k]   <= b_d[k];
        sum_p[k] <= sum_d[k];
        cy_p[k]  <= cy_d[k];
      end
    end
  end

  // Output stage: signed overflow uses the effective (possibly inverted) B sign
  assign sum   = sum_p[NSTG-1];
  assign c_out = cy_p[NSTG-1];
  assign ovf   = (a_p[NSTG-1][W-1] == b_p[NSTG-1][W-1]) &
                 (sum_p[NSTG-1][W-1] != a_p[NSTG-1][W-1]);

endmodule
